// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order retirement of up to COMMIT_W completed entries per cycle.
// Latency: CDB completion to registered commit outputs is one edge; allocate-to-commit round trip is two cycles.
// Backpressure: alloc_ready drops while the buffer is full or during the one-cycle flush pulse.
module rob_commit_unit #(
    parameter int ROB_DEPTH = 16,
    parameter int COMMIT_W  = 4,
    parameter int CDB_W     = 2,
    parameter int PHY_W     = 7,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_valid,
    input  logic                        alloc_has_dst,
    input  logic [PHY_W-1:0]            alloc_phy_dst,
    input  logic                        alloc_is_branch,
    output logic                        alloc_ready,
    output logic [TAG_W-1:0]            alloc_tag,
    output logic                        rob_full,
    input  logic [CDB_W-1:0]            cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]      cdb_tag,
    input  logic [CDB_W-1:0]            cdb_mispredict,
    output logic [COMMIT_W-1:0]         commit_valid,
    output logic [COMMIT_W-1:0]         commit_with_write,
    output logic [COMMIT_W*PHY_W-1:0]   commited_wr_register,
    output logic [COMMIT_W*TAG_W-1:0]   commit_tag,
    output logic                        flush
);

    localparam int CNT_W = TAG_W + 1;
    localparam int K_W   = $clog2(COMMIT_W + 1);

    typedef struct packed {
        logic             valid;
        logic             done;
        logic             has_dst;
        logic [PHY_W-1:0] phy_dst;
        logic             is_branch;
        logic             mispred;
    } rob_entry_t;

    rob_entry_t                rob [ROB_DEPTH];
    logic [TAG_W-1:0]          head;
    logic [TAG_W-1:0]          tail;
    logic [CNT_W-1:0]          count;

    logic                      alloc_fire;
    logic [TAG_W-1:0]          slot_idx [COMMIT_W];
    logic [COMMIT_W-1:0]       sel_mask;
    logic [K_W-1:0]            sel_k;
    logic                      sel_flush;
    logic [TAG_W-1:0]          br_idx;
    logic                      scan_stop;
    logic [ROB_DEPTH-1:0]      cdb_hit;
    logic [ROB_DEPTH-1:0]      cdb_mis;
    logic [ROB_DEPTH-1:0]      commit_clr;

    logic [TAG_W-1:0]          head_nxt;
    logic [TAG_W-1:0]          tail_nxt;
    logic [CNT_W-1:0]          count_nxt;
    logic [COMMIT_W-1:0]       cww_d;
    logic [COMMIT_W*PHY_W-1:0] creg_d;
    logic [COMMIT_W*TAG_W-1:0] ctag_d;

    assign alloc_ready = (count != CNT_W'(ROB_DEPTH)) && !flush;
    assign rob_full    = ~alloc_ready;
    assign alloc_tag   = tail;
    assign alloc_fire  = alloc_valid && alloc_ready;

    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            slot_idx[i] = head + TAG_W'(i);
        end
    end

    // Head-first scan over registered state; a mispredicted branch closes the window after itself.
    always_comb begin
        sel_mask  = '0;
        sel_flush = 1'b0;
        br_idx    = head;
        scan_stop = 1'b0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (!scan_stop && rob[slot_idx[i]].valid && rob[slot_idx[i]].done) begin
                sel_mask[i] = 1'b1;
                if (rob[slot_idx[i]].mispred) begin
                    sel_flush = 1'b1;
                    br_idx    = slot_idx[i];
                    scan_stop = 1'b1;
                end
            end else begin
                scan_stop = 1'b1;
            end
        end
    end

    assign sel_k = K_W'($countones(sel_mask));

    // Same-tag hits from several ports merge by OR-ing their mispredict bits.
    always_comb begin
        cdb_hit = '0;
        cdb_mis = '0;
        for (int p = 0; p < CDB_W; p++) begin
            if (cdb_valid[p]) begin
                cdb_hit[cdb_tag[p*TAG_W +: TAG_W]] = 1'b1;
                cdb_mis[cdb_tag[p*TAG_W +: TAG_W]] = cdb_mis[cdb_tag[p*TAG_W +: TAG_W]] | cdb_mispredict[p];
            end
        end
        for (int e = 0; e < ROB_DEPTH; e++) begin
            cdb_hit[e] = cdb_hit[e] & rob[e].valid;
            cdb_mis[e] = cdb_mis[e] & cdb_hit[e] & rob[e].is_branch;
        end
    end

    always_comb begin
        commit_clr = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (sel_mask[i]) begin
                commit_clr[slot_idx[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        if (sel_flush) begin
            head_nxt  = br_idx + TAG_W'(1);
            tail_nxt  = br_idx + TAG_W'(1);
            count_nxt = '0;
        end else begin
            head_nxt  = head + TAG_W'(sel_k);
            tail_nxt  = tail + TAG_W'(alloc_fire);
            count_nxt = count + CNT_W'(alloc_fire) - CNT_W'(sel_k);
        end
    end

    always_comb begin
        cww_d  = '0;
        creg_d = '0;
        ctag_d = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (sel_mask[i]) begin
                cww_d[i]                  = rob[slot_idx[i]].has_dst;
                creg_d[i*PHY_W +: PHY_W]  = rob[slot_idx[i]].phy_dst;
                ctag_d[i*TAG_W +: TAG_W]  = slot_idx[i];
            end
        end
    end

    // A flush clears every entry: older ones retire at the same edge, younger ones are squashed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                rob[e] <= '0;
            end
        end else begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                if (cdb_hit[e]) begin
                    rob[e].done    <= 1'b1;
                    rob[e].mispred <= cdb_mis[e];
                end
                if (commit_clr[e] || sel_flush) begin
                    rob[e].valid <= 1'b0;
                end
            end
            if (alloc_fire && !sel_flush) begin
                rob[tail] <= '{valid: 1'b1, done: 1'b0, has_dst: alloc_has_dst,
                               phy_dst: alloc_phy_dst, is_branch: alloc_is_branch,
                               mispred: 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            commit_valid         <= '0;
            commit_with_write    <= '0;
            commited_wr_register <= '0;
            commit_tag           <= '0;
            flush                <= 1'b0;
        end else begin
            head                 <= head_nxt;
            tail                 <= tail_nxt;
            count                <= count_nxt;
            commit_valid         <= sel_mask;
            commit_with_write    <= cww_d;
            commited_wr_register <= creg_d;
            commit_tag           <= ctag_d;
            flush                <= sel_flush;
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed scenarios on the default build plus a randomised run on an 8-entry, 2-wide build.
module tb_rob_commit_unit;

    localparam int D  = 16;
    localparam int C  = 4;
    localparam int W  = 2;
    localparam int P  = 7;
    localparam int T  = 4;
    localparam int D2 = 8;
    localparam int C2 = 2;
    localparam int T2 = 3;

    logic clk;
    logic reset;

    logic             alloc_valid, alloc_has_dst, alloc_is_branch;
    logic [P-1:0]     alloc_phy_dst;
    logic             alloc_ready, rob_full, flush;
    logic [T-1:0]     alloc_tag;
    logic [W-1:0]     cdb_valid, cdb_mispredict;
    logic [W*T-1:0]   cdb_tag;
    logic [C-1:0]     commit_valid, commit_with_write;
    logic [C*P-1:0]   commited_wr_register;
    logic [C*T-1:0]   commit_tag;

    logic             alloc_valid_b, alloc_has_dst_b, alloc_is_branch_b;
    logic [P-1:0]     alloc_phy_dst_b;
    logic             alloc_ready_b, rob_full_b, flush_b;
    logic [T2-1:0]    alloc_tag_b;
    logic [W-1:0]     cdb_valid_b, cdb_mispredict_b;
    logic [W*T2-1:0]  cdb_tag_b;
    logic [C2-1:0]    commit_valid_b, commit_with_write_b;
    logic [C2*P-1:0]  commited_wr_register_b;
    logic [C2*T2-1:0] commit_tag_b;

    rob_commit_unit #(.ROB_DEPTH(D), .COMMIT_W(C), .CDB_W(W), .PHY_W(P)) u_dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_has_dst(alloc_has_dst), .alloc_phy_dst(alloc_phy_dst),
        .alloc_is_branch(alloc_is_branch), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .rob_full(rob_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_mispredict(cdb_mispredict),
        .commit_valid(commit_valid), .commit_with_write(commit_with_write),
        .commited_wr_register(commited_wr_register), .commit_tag(commit_tag), .flush(flush)
    );

    rob_commit_unit #(.ROB_DEPTH(D2), .COMMIT_W(C2), .CDB_W(W), .PHY_W(P)) u_dut_b (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid_b), .alloc_has_dst(alloc_has_dst_b), .alloc_phy_dst(alloc_phy_dst_b),
        .alloc_is_branch(alloc_is_branch_b), .alloc_ready(alloc_ready_b), .alloc_tag(alloc_tag_b),
        .rob_full(rob_full_b), .cdb_valid(cdb_valid_b), .cdb_tag(cdb_tag_b), .cdb_mispredict(cdb_mispredict_b),
        .commit_valid(commit_valid_b), .commit_with_write(commit_with_write_b),
        .commited_wr_register(commited_wr_register_b), .commit_tag(commit_tag_b), .flush(flush_b)
    );

    typedef struct packed {
        logic [C-1:0]   v;
        logic [C-1:0]   w;
        logic [C*P-1:0] r;
        logic [C*T-1:0] t;
        logic           fl;
    } exp_t;

    exp_t     exp_q[$];
    exp_t     mon_e;
    int       tag_q[$];
    int       pend[$];
    int       exp_tag;
    int       outstanding;
    int       checks;
    int       failures;

    initial begin
        clk = 1'b0;
        #3;
        forever begin
            clk = 1'b1;
            #5;
            clk = 1'b0;
            #5;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [C-1:0] v, input logic [C-1:0] w,
                                input logic [C*P-1:0] r, input logic [C*T-1:0] t, input logic fl);
        exp_t e;
        e.v = v; e.w = w; e.r = r; e.t = t; e.fl = fl;
        return e;
    endfunction

    // Scoreboard for the default build: every commit or flush cycle consumes one expected record.
    always @(negedge clk) begin
        if (reset === 1'b1 && (commit_valid !== '0 || flush !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit actual valid=%b flush=%b required no output", commit_valid, flush);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_valid", commit_valid, mon_e.v);
                check("commit_with_write", commit_with_write, mon_e.w);
                check("commited_wr_register", commited_wr_register, mon_e.r);
                check("commit_tag", commit_tag, mon_e.t);
                check("flush", flush, mon_e.fl);
            end
        end
    end

    // Random-run monitor: contiguous mask, in-order tags, no flush.
    always @(negedge clk) begin
        if (reset === 1'b1 && commit_valid_b !== '0) begin
            check("rand_contiguous", commit_valid_b == 2'b10, 0);
            check("rand_flush", flush_b, 0);
            for (int i = 0; i < C2; i++) begin
                if (commit_valid_b[i]) begin
                    outstanding--;
                    if (tag_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rand_extra_commit actual tag=%0d required none", commit_tag_b[i*T2 +: T2]);
                    end else begin
                        exp_tag = tag_q.pop_front();
                        check("rand_commit_tag", commit_tag_b[i*T2 +: T2], exp_tag);
                    end
                end
            end
        end
    end

    task automatic alloc(input logic has_dst, input logic [P-1:0] phy, input logic br);
        alloc_valid     = 1'b1;
        alloc_has_dst   = has_dst;
        alloc_phy_dst   = phy;
        alloc_is_branch = br;
        @(negedge clk);
        alloc_valid     = 1'b0;
        alloc_has_dst   = 1'b0;
        alloc_phy_dst   = '0;
        alloc_is_branch = 1'b0;
    endtask

    task automatic cdb(input logic [W-1:0] v, input logic [T-1:0] t0, input logic [T-1:0] t1,
                       input logic [W-1:0] m);
        cdb_valid      = v;
        cdb_tag        = {t1, t0};
        cdb_mispredict = m;
        @(negedge clk);
        cdb_valid      = '0;
        cdb_tag        = '0;
        cdb_mispredict = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0; outstanding = 0;
        reset = 1'b0;
        alloc_valid = 0; alloc_has_dst = 0; alloc_phy_dst = '0; alloc_is_branch = 0;
        cdb_valid = '0; cdb_tag = '0; cdb_mispredict = '0;
        alloc_valid_b = 0; alloc_has_dst_b = 0; alloc_phy_dst_b = '0; alloc_is_branch_b = 0;
        cdb_valid_b = '0; cdb_tag_b = '0; cdb_mispredict_b = '0;

        // Reset state, then reset in the middle of activity.
        #35 reset = 1'b1;
        @(negedge clk);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_commit_with_write", commit_with_write, 0);
        check("rst_commited_wr_register", commited_wr_register, 0);
        check("rst_commit_tag", commit_tag, 0);
        check("rst_flush", flush, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_tag", alloc_tag, 0);
        check("rst_rob_full", rob_full, 0);
        for (int i = 0; i < 5; i++) alloc(1'b1, 7'(i), 1'b0);
        check("pre_rst_alloc_tag", alloc_tag, 5);
        cdb(2'b11, 4'd0, 4'd1, 2'b00);
        reset = 1'b0;
        #1;
        check("mid_rst_alloc_tag", alloc_tag, 0);
        check("mid_rst_alloc_ready", alloc_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_no_commit", commit_valid, 0);

        // Four-wide commit after out-of-order completion.
        do_reset();
        alloc(1'b1, 7'd4, 1'b0);
        alloc(1'b1, 7'd5, 1'b0);
        alloc(1'b0, 7'd6, 1'b0);
        alloc(1'b1, 7'd7, 1'b0);
        exp_q.push_back(mk(4'b1111, 4'b1011, {7'd7, 7'd6, 7'd5, 7'd4}, {4'd3, 4'd2, 4'd1, 4'd0}, 1'b0));
        cdb(2'b11, 4'd3, 4'd2, 2'b00);
        cdb(2'b11, 4'd1, 4'd0, 2'b00);
        check("t2_not_early", commit_valid, 0);
        @(negedge clk);
        check("t2_latency", commit_valid, 4'b1111);
        drain("t2_drain");

        // Full buffer, rejected allocation, wrap after one commit.
        do_reset();
        for (int i = 0; i < D; i++) alloc(1'b1, 7'(16 + i), 1'b0);
        check("t3_rob_full", rob_full, 1);
        check("t3_alloc_ready", alloc_ready, 0);
        check("t3_alloc_tag_wrap", alloc_tag, 0);
        alloc(1'b1, 7'd99, 1'b0);
        check("t3_rejected_tag", alloc_tag, 0);
        check("t3_still_full", rob_full, 1);
        exp_q.push_back(mk(4'b0001, 4'b0001, {21'd0, 7'd16}, 16'd0, 1'b0));
        cdb(2'b01, 4'd0, 4'd0, 2'b00);
        check("t3_full_during_commit", alloc_ready, 0);
        @(negedge clk);
        check("t3_ready_after_commit", alloc_ready, 1);
        check("t3_tag_after_commit", alloc_tag, 0);
        drain("t3_drain");

        // Younger entries done but head not done: nothing retires until head completes.
        do_reset();
        alloc(1'b1, 7'd10, 1'b0);
        alloc(1'b1, 7'd11, 1'b0);
        alloc(1'b1, 7'd12, 1'b0);
        cdb(2'b11, 4'd1, 4'd2, 2'b00);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("t4_blocked", commit_valid, 0);
        end
        exp_q.push_back(mk(4'b0111, 4'b0111, {7'd0, 7'd12, 7'd11, 7'd10}, {4'd0, 4'd2, 4'd1, 4'd0}, 1'b0));
        cdb(2'b01, 4'd0, 4'd0, 2'b00);
        drain("t4_drain");

        // Mispredicted branch at tag 2 flushes 3..5 and an allocation made at the flush edge.
        do_reset();
        for (int i = 0; i < 6; i++) alloc(i != 2, 7'(20 + i), i == 2);
        cdb(2'b11, 4'd3, 4'd4, 2'b00);
        cdb(2'b11, 4'd5, 4'd2, 2'b10);
        exp_q.push_back(mk(4'b0111, 4'b0011, {7'd0, 7'd22, 7'd21, 7'd20}, {4'd0, 4'd2, 4'd1, 4'd0}, 1'b1));
        cdb(2'b11, 4'd0, 4'd1, 2'b00);
        alloc(1'b1, 7'd99, 1'b0);
        check("t5_flush_pulse", flush, 1);
        check("t5_ready_in_flush", alloc_ready, 0);
        check("t5_tag_in_flush", alloc_tag, 3);
        @(negedge clk);
        check("t5_flush_single", flush, 0);
        check("t5_ready_after_flush", alloc_ready, 1);
        check("t5_tag_after_flush", alloc_tag, 3);
        cdb(2'b01, 4'd4, 4'd0, 2'b00);
        alloc(1'b1, 7'd33, 1'b0);
        exp_q.push_back(mk(4'b0001, 4'b0001, {21'd0, 7'd33}, {12'd0, 4'd3}, 1'b0));
        cdb(2'b01, 4'd3, 4'd0, 2'b00);
        drain("t5_drain");
        repeat (3) @(negedge clk);

        // Random traffic on the 8-entry, 2-wide build.
        do_reset();
        outstanding = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            cdb_valid_b = '0;
            cdb_tag_b   = '0;
            for (int p = 0; p < W; p++) begin
                if (pend.size() > 0 && ($urandom % 2) == 1) begin
                    int j;
                    j = $urandom_range(pend.size() - 1, 0);
                    cdb_tag_b[p*T2 +: T2] = T2'(pend[j]);
                    cdb_valid_b[p] = 1'b1;
                    pend.delete(j);
                end
            end
            alloc_valid_b   = 1'($urandom % 2);
            alloc_has_dst_b = 1'($urandom % 2);
            alloc_phy_dst_b = 7'($urandom % 128);
            if (alloc_valid_b && alloc_ready_b) begin
                tag_q.push_back(int'(alloc_tag_b));
                pend.push_back(int'(alloc_tag_b));
                outstanding++;
                check("rand_count_bound", outstanding <= D2, 1);
            end
            @(negedge clk);
        end
        #1;
        alloc_valid_b = 1'b0;
        for (int n = 0; n < 20 && pend.size() > 0; n++) begin
            cdb_valid_b = '0;
            cdb_tag_b   = '0;
            for (int p = 0; p < W; p++) begin
                if (pend.size() > 0) begin
                    cdb_tag_b[p*T2 +: T2] = T2'(pend.pop_front());
                    cdb_valid_b[p] = 1'b1;
                end
            end
            @(negedge clk);
            #1;
        end
        cdb_valid_b = '0;
        for (int n = 0; n < 30 && tag_q.size() > 0; n++) @(negedge clk);
        check("rand_all_committed", tag_q.size(), 0);
        check("rand_outstanding_end", outstanding, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Parametrised reorder buffer and in-order commit engine for the OOO RISC-V core.
- Allocates one tag per dispatched instruction and marks entries complete from up to CDB_W CDB broadcasts per cycle.
- Retires up to COMMIT_W completed head entries per cycle. Its commit outputs feed the IDU free-list (commit_valid / commit_with_write / commited_wr_register) and the RS commit interface.
- Resolves branch mispredictions at commit by raising flush and discarding all younger entries; this replaces hand-driven commit and flush stimulus at integration level.

Parameters:
- ROB_DEPTH, 16, number of entries; must be a power of 2, ≥ COMMIT_W.
- COMMIT_W, 4, maximum commits per cycle (matches MAX_NUM_OF_COMMITS).
- CDB_W, 2, number of CDB result ports sampled per cycle.
- PHY_W, 7, physical register number width (matches PHYSICAL_REG_NUM_WIDTH).
- TAG_W, $clog2(ROB_DEPTH), tag width (derived).

Ports:
- clk  in  1  core clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  dispatch requests an entry this cycle.
- alloc_has_dst  in  1  instruction writes a physical register.
- alloc_phy_dst  in  PHY_W  physical destination register.
- alloc_is_branch  in  1  instruction is a conditional branch or jump.
- alloc_ready  out  1  entry available; an allocation occurs only when alloc_valid & alloc_ready.
- alloc_tag  out  TAG_W  tag assigned to the current allocation (equals the tail pointer).
- rob_full  out  1  ~alloc_ready.
- cdb_valid  in  CDB_W  per-port result valid.
- cdb_tag  in  CDB_W*TAG_W  per-port completing tag.
- cdb_mispredict  in  CDB_W  per-port branch mispredicted (ignored unless the entry is a branch).
- commit_valid  out  COMMIT_W  slot i retires an instruction; always a contiguous mask from bit 0.
- commit_with_write  out  COMMIT_W  slot i retired with a register write.
- commited_wr_register  out  COMMIT_W*PHY_W  physical register freed per slot.
- commit_tag  out  COMMIT_W*TAG_W  retired tag per slot.
- flush  out  1  misprediction flush pulse.

Behaviour:
- Per-entry state: valid, done, has_dst, phy_dst, is_branch, mispred. Also head, tail (TAG_W bits, wrap modulo ROB_DEPTH) and count (TAG_W+1 bits).
- Reset (asserted low, async):
  - all entries invalid; head = tail = count = 0.
  - commit_valid, commit_with_write, commited_wr_register, commit_tag = 0; flush = 0.
  - alloc_ready = 1; alloc_tag = 0.
  - Reset mid-operation discards everything; no commit or flush is emitted afterwards.
- alloc_ready = (count != ROB_DEPTH) & ~flush. This is combinational from registered state; entries freed at an edge become allocatable only from the next cycle.
- Allocate at posedge when alloc_valid & alloc_ready:
  - the tail entry becomes valid with done = 0 and the inputs captured;
  - tail increments, wrapping ROB_DEPTH-1 → 0.
- Writeback at posedge: for each port p with cdb_valid[p], the entry at cdb_tag[p] sets done = 1, and sets mispred = cdb_mispredict[p] & is_branch.
  - A CDB hit on an invalid entry is ignored.
  - Two ports naming the same tag: the OR of the mispredict bits is taken.
- Commit selection uses registered done bits only:
  - k = number of consecutive valid & done entries starting at head, capped at COMMIT_W;
  - the scan stops after the first entry with mispred = 1, which is itself included.
- At posedge, the k selected entries are invalidated and head advances by k (wrapping).
  - Commit outputs are registered and valid in the cycle following that edge.
  - Slot i = head+i; commit_with_write[i] = has_dst; unused slots drive 0.
- Latency:
  - allocate at edge 0, CDB at edge 1, commit decided at edge 2;
  - commit_valid is high from edge 2 to edge 3; a single-entry round trip is 2 cycles.
- Mispredict: when a selected slot has mispred = 1, at the same edge:
  - every entry younger than it is invalidated;
  - tail = head = branch index + 1 and count = 0;
  - flush is registered high for exactly one cycle, aligned with that commit's outputs;
  - alloc_ready is 0 during the flush cycle.
- Simultaneous events at one edge:
  - Allocate + commit: count_next = count + alloc − k.
  - Allocate + mispredict commit: the allocation is discarded, since it is younger.
  - CDB for a tag being flushed is ignored.
- Full with a commit in the same cycle: alloc_ready stays 0 that cycle and rises the next cycle.
- Commit_valid is never non-contiguous, and the unit never commits past tail.

Test Plan:
1. Reset low for 35 ns, then release → all outputs 0, alloc_ready = 1, alloc_tag = 0. Asserting reset after 5 allocations → count = 0 and no commit_valid.
2. Allocate tags 0..3 with phy_dst 4,5,6,7 and has_dst = 1,1,0,1. CDB completes 3,2,1,0 over 2 cycles (two tags per cycle) → one cycle after the last CDB edge: commit_valid = 4'b1111, commit_with_write = 4'b1011, commited_wr_register = {7,6,5,4}.
3. Allocate 16 with no CDB → rob_full = 1 after the 16th allocation, and a 17th alloc_valid is not accepted. Complete tag 0 → one cycle after commit, alloc_ready = 1 and alloc_tag = 0 (wrap).
4. Out of order: complete tags 1 and 2 but not 0 → commit_valid stays 0. Then complete tag 0 → a single cycle with commit_valid = 4'b0111.
5. Allocate tags 0..5 with tag 2 as a branch. Complete all, with mispredict on tag 2 → commit_valid = 4'b0111 with flush = 1 for one cycle; tags 3..5 are never committed; the next alloc_tag = 3.
6. Run 40 cycles of random alloc/CDB with COMMIT_W = 2 and ROB_DEPTH = 8 → commit_tag sequence strictly in allocation order modulo 8, never more than 2 commits per cycle, and count never exceeds 8.
